k_sync_fifo_t2: RTL
===================

K_SYNC_FIFO_T2 -- requirements
Module: k_sync_fifo_t2

Interface
REQ-001 The block SHALL have parameter data_size, default 8, meaning the width of a word in bits.
REQ-002 The block SHALL have parameter addr_size, default 2, meaning log2 of the depth; depth is 2**addr_size (default 4).
REQ-003 The block SHALL have parameter afull_lvl, default 3, meaning the almost-full threshold in words (legal range 1..depth).
REQ-004 The block SHALL have parameter aempty_lvl, default 1, meaning the almost-empty threshold in words (legal range 0..depth-1).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, on these ports (clock and reset listed first):
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wdata  input  data_size  write data.
- wput  input  1  write request.
- wrdy  output  1  FIFO can accept a word (not full).
- rdata  output  data_size  head-of-queue word; valid while rrdy=1.
- rget  input  1  read/pop request.
- rrdy  output  1  FIFO holds at least one word (not empty).
- count  output  addr_size+1  current occupancy, 0..depth.
- afull  output  1  count >= afull_lvl.
- aempty  output  1  count <= aempty_lvl.

Function
REQ-006 Storage SHALL be a depth-entry register array, written at wptr on an accepted write.
REQ-007 wptr and rptr SHALL each be addr_size+1 bits; the low addr_size bits address storage and the MSB is the wrap bit.
REQ-008 A write SHALL be accepted when wput=1 and wrdy=1 at a clk edge; wptr increments by 1 modulo 2**(addr_size+1).
REQ-009 A read SHALL be accepted when rget=1 and rrdy=1 at a clk edge; rptr increments by 1 modulo 2**(addr_size+1).
REQ-010 wrdy and rrdy SHALL be decoded from registered state only and SHALL NOT depend combinationally on wput or rget.
REQ-011 Full condition: pointer MSBs differ and the low bits are equal; wrdy=0 when full.
REQ-012 Empty condition: pointers are equal; rrdy=0 when empty.
REQ-013 rdata SHALL be first-word-fall-through: it combinationally shows storage at rptr, with zero-cycle read latency.
REQ-014 After a write to an empty FIFO at edge N, rrdy=1 and rdata=the written word SHALL hold from edge N.
REQ-015 When the FIFO is full, wput SHALL be ignored even if a read is accepted in the same cycle; storage and wptr stay unchanged.
REQ-016 When the FIFO is empty, rget SHALL be ignored; rptr stays unchanged.
REQ-017 A simultaneous accepted read and write SHALL leave count unchanged and update both pointers.
REQ-018 count SHALL be a register: +1 on a write only, -1 on a read only, unchanged otherwise; it never exceeds depth and never underflows.
REQ-019 afull and aempty SHALL be combinational compares on count.

Reset
REQ-020 On rst_n=0, wptr, rptr and count SHALL clear to 0 asynchronously; consequently rrdy=0, wrdy=1, aempty=1, and afull=(afull_lvl==0 ? 1 : 0).
REQ-021 Storage contents SHALL NOT be reset; rdata is don't-care while rrdy=0.
REQ-022 Reset asserted mid-operation SHALL discard all queued words; deassertion SHALL take effect synchronously to the next clk edge with no spurious transfer.

Configuration
REQ-023 Macro K_SFIFO_ERR_EN: when it is defined, the block SHALL add input err_clr and outputs ovf and udf (each 1 bit).
- ovf: sticky; set on any edge with wput=1 and wrdy=0.
- udf: sticky; set on any edge with rget=1 and rrdy=0.
- Both clear on reset or on err_clr=1; when set and clear occur in the same cycle, set SHALL win.
REQ-024 Without K_SFIFO_ERR_EN, the block SHALL have no err_clr, ovf or udf ports and no corresponding logic; all other behaviour is identical.

Verification
REQ-025 Reset then fill: apply rst_n=0, then 4 writes of 0xA0..0xA3 (defaults) -> count 1,2,3,4; afull rises at count=3; wrdy=0 after the 4th write; rdata=0xA0 throughout.
REQ-026 Drain in order: from full, assert rget for 4 cycles -> rdata 0xA0,0xA1,0xA2,0xA3; rrdy=0 and aempty=1 after the last read.
REQ-027 Full boundary: at full, assert wput=1 and rget=1 together -> the read is accepted and the write ignored; count=3; wptr unchanged; ovf=1 when K_SFIFO_ERR_EN is defined.
REQ-028 Empty boundary: at empty, assert wput=1 (0x55) and rget=1 together -> the write is accepted and the read ignored; count=1; rdata=0x55 next cycle; udf=1 when K_SFIFO_ERR_EN is defined.
REQ-029 Wrap-around: run 10 interleaved write/read pairs at count=2 -> data order is preserved across pointer wrap and count stays 2.
REQ-030 Mid-operation reset: pulse rst_n low between clk edges at count=3 -> count=0, rrdy=0 and wrdy=1 immediately; no write or read occurs on the first edge after release.

Source files
------------

// File: rtl/k_sync_fifo_t2.sv
// +----------------------------------------------------------------------------+
// | Module   : k_sync_fifo_t2                                                  |
// | Purpose  : single-clock first-word-fall-through FIFO with occupancy count, |
// |            almost-full/almost-empty flags.                                 |
// |            Define K_SFIFO_ERR_EN to add sticky ovf/udf flags and err_clr.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module k_sync_fifo_t2 #(
  parameter int data_size  = 8,
  parameter int addr_size  = 2,
  parameter int afull_lvl  = 3,
  parameter int aempty_lvl = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [data_size-1:0] wdata,
  input  logic                 wput,
  output logic                 wrdy,
  output logic [data_size-1:0] rdata,
  input  logic                 rget,
  output logic                 rrdy,
  output logic [addr_size:0]   count,
  output logic                 afull,
  output logic                 aempty
`ifdef K_SFIFO_ERR_EN
  ,
  input  logic                 err_clr,
  output logic                 ovf,
  output logic                 udf
`endif
);

  localparam int                 c_depth  = 1 << addr_size;
  localparam logic [addr_size:0] c_one    = {{addr_size{1'b0}}, 1'b1};
  localparam logic [addr_size:0] c_afull  = afull_lvl[addr_size:0];
  localparam logic [addr_size:0] c_aempty = aempty_lvl[addr_size:0];

  logic [data_size-1:0] r_mem [c_depth];
  logic [addr_size:0]   r_wptr;
  logic [addr_size:0]   r_rptr;
  logic [addr_size:0]   r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_en;
  logic                 w_rd_en;

  // Flags come from the pointers only, so wput/rget never feed back into wrdy/rrdy.
  assign w_full  = (r_wptr[addr_size] != r_rptr[addr_size]) &&
                   (r_wptr[addr_size-1:0] == r_rptr[addr_size-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign wrdy    = ~w_full;
  assign rrdy    = ~w_empty;
  assign w_wr_en = wput & wrdy;
  assign w_rd_en = rget & rrdy;

  assign rdata  = r_mem[r_rptr[addr_size-1:0]];
  assign count  = r_count;
  assign afull  = (r_count >= c_afull);
  assign aempty = (r_count <= c_aempty);

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[addr_size-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + c_one;
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + c_one;
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + c_one;
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - c_one;
      end
    end
  end

`ifdef K_SFIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  assign ovf = r_ovf;
  assign udf = r_udf;

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (wput & ~wrdy) | (r_ovf & ~err_clr);
      r_udf <= (rget & ~rrdy) | (r_udf & ~err_clr);
    end
  end
`endif

endmodule

`default_nettype wire
